// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state type, field widths and saturation helpers for the MM:SS countdown timer
package countdown_pkg;

  localparam int MIN_W = 8;
  localparam int SEC_W = 6;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [MIN_W-1:0] sat_min(
    input logic [MIN_W-1:0] v,
    input logic [MIN_W-1:0] max
  );
    return (v > max) ? max : v;
  endfunction

  function automatic logic [SEC_W-1:0] sat_sec(input logic [SEC_W-1:0] v);
    return (v > SEC_MAX) ? SEC_MAX : v;
  endfunction

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle tick every TICKS_PER_SEC enabled cycles
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [W-1:0] TERM = W'(TICKS_PER_SEC - 1);

  logic [W-1:0] r_cnt;

  // terminal count only produces a tick while enabled, so a frozen counter holds it
  always_comb tick = en & (r_cnt == TERM);

  // counter: clear wins over enable, wraps to zero on the tick
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      r_cnt <= '0;
    else if (clr)
      r_cnt <= '0;
    else if (en)
      r_cnt <= tick ? '0 : r_cnt + W'(1);

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS countdown with load/start/pause/clear; optional COUNTDOWN_AUTO_RELOAD_EN restarts from the stored value
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int MIN_MAX       = 99
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [SEC_W-1:0] load_sec,
  input  logic             start,
  input  logic             pause,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic             running,
  output logic             expired,
  output logic             done_pulse
);

  localparam logic [MIN_W-1:0] L_MIN_MAX = MIN_W'(MIN_MAX);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [MIN_W-1:0] r_min;
  logic [SEC_W-1:0] r_sec;
  logic             r_done_pulse;
  logic             r_reload_pend;

  logic [MIN_W-1:0] w_rl_min;
  logic [SEC_W-1:0] w_rl_sec;
  logic [MIN_W-1:0] w_ld_min;
  logic [SEC_W-1:0] w_ld_sec;
  logic [MIN_W-1:0] w_dec_min;
  logic [SEC_W-1:0] w_dec_sec;
  logic             w_ctrl;
  logic             w_nonzero;
  logic             w_arm;
  logic             w_valid_start;
  logic             w_do_pause;
  logic             w_psc_clr;
  logic             w_psc_en;
  logic             w_tick;
  logic             w_dec;
  logic             w_hit_zero;
  logic             w_auto;
  logic             w_reload_now;

  assign w_ld_min = sat_min(load_min, L_MIN_MAX);
  assign w_ld_sec = sat_sec(load_sec);

  assign w_ctrl        = clear | load;
  assign w_nonzero     = (r_min != '0) | (r_sec != '0);
  assign w_arm         = start & ((r_state == IDLE) | (r_state == DONE)) & w_nonzero;
  assign w_valid_start = w_arm | (start & (r_state == PAUSE));
  assign w_do_pause    = pause & (r_state == RUN);

  // a fresh start restarts the second; resume from PAUSE keeps the partial second
  assign w_psc_clr = w_ctrl | w_arm;
  assign w_psc_en  = (r_state == RUN) & ~pause;

  assign w_dec      = w_tick & ~w_ctrl & w_nonzero;
  assign w_hit_zero = w_dec & (r_min == '0) & (r_sec == SEC_W'(1));

  assign w_dec_sec = (r_sec != '0) ? r_sec - SEC_W'(1) : SEC_MAX;
  assign w_dec_min = (r_sec != '0) ? r_min : r_min - MIN_W'(1);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [MIN_W-1:0] r_rl_min;
  logic [SEC_W-1:0] r_rl_sec;

  // reload value is only changed by load; clear leaves it intact
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rl_min <= '0;
      r_rl_sec <= '0;
    end else if (load) begin
      r_rl_min <= w_ld_min;
      r_rl_sec <= w_ld_sec;
    end

  assign w_rl_min = r_rl_min;
  assign w_rl_sec = r_rl_sec;
`else
  assign w_rl_min = '0;
  assign w_rl_sec = '0;
`endif

  assign w_auto       = (w_rl_min != '0) | (w_rl_sec != '0);
  assign w_reload_now = r_reload_pend & ~w_ctrl;

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_psc_clr),
    .en   (w_psc_en),
    .tick (w_tick)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;

  // next state: clear/load > start > pause > expiry; auto-reload keeps RUN at zero
  always_comb
    w_state_nxt = w_ctrl                    ? IDLE  :
                  w_valid_start             ? RUN   :
                  w_do_pause                ? PAUSE :
                  (w_hit_zero & ~w_auto)    ? DONE  : r_state;

  // outputs are decodes of the registered state plus the registered expiry pulse
  always_comb begin
    running    = (r_state == RUN);
    expired    = (r_state == DONE);
    done_pulse = r_done_pulse;
  end

  // MM:SS datapath: control actions override the reload and the tick decrement
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_min <= '0;
      r_sec <= '0;
    end else if (clear) begin
      r_min <= '0;
      r_sec <= '0;
    end else if (load) begin
      r_min <= w_ld_min;
      r_sec <= w_ld_sec;
    end else if (w_reload_now) begin
      r_min <= w_rl_min;
      r_sec <= w_rl_sec;
    end else if (w_dec) begin
      r_min <= w_dec_min;
      r_sec <= w_dec_sec;
    end

  // expiry pulse lands with the 00:00 update; reload follows one cycle later
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_done_pulse  <= 1'b0;
      r_reload_pend <= 1'b0;
    end else begin
      r_done_pulse  <= w_hit_zero;
      r_reload_pend <= w_hit_zero & w_auto;
    end

  assign minutes = r_min;
  assign seconds = r_sec;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench for countdown_timer with TICKS_PER_SEC=4
module tb_countdown_timer;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] load_min = '0;
  logic [5:0] load_sec = '0;
  logic [7:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       expired;
  logic       done_pulse;

  countdown_timer #(
    .TICKS_PER_SEC(TPS),
    .MIN_MAX      (99)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .load      (load),
    .load_min  (load_min),
    .load_sec  (load_sec),
    .start     (start),
    .pause     (pause),
    .minutes   (minutes),
    .seconds   (seconds),
    .running   (running),
    .expired   (expired),
    .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [13:0] v;
    logic       dp;
  } ev_t;

  ev_t         q[$];
  ev_t         e;
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;
  logic [13:0] prev = '0;
  logic [13:0] cur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // every output change or done_pulse is matched against the next expected event
  always @(negedge clk) begin
    cur = {minutes, seconds};
    if (mon_en && (cur !== prev || done_pulse === 1'b1)) begin
      if (q.size() == 0)
        check("unexpected_event", {18'd0, cur}, 32'hFFFF_FFFF);
      else begin
        e = q.pop_front();
        check("ev_cycle", cyc, e.c);
        check("ev_value", {18'd0, cur}, {18'd0, e.v});
        check("ev_done_pulse", {31'd0, done_pulse}, {31'd0, e.dp});
      end
    end
    prev = cur;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [7:0] m, input logic [5:0] s, input logic dp);
    q.push_back('{c, {m, s}, dp});
  endtask

  task automatic do_load(input logic [7:0] m, input logic [5:0] s,
                         input logic [7:0] em, input logic [5:0] es);
    load_min = m;
    load_sec = s;
    load = 1'b1;
    push(cyc + 1, em, es, 1'b0);
    step(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    push(cyc + 1, 8'd0, 6'd0, 1'b0);
    step(1);
    clear = 1'b0;
  endtask

  int e0;

  initial begin
    #2 rst_n = 1'b0;
    #2;
    check("rst_minutes", {24'd0, minutes}, 32'd0);
    check("rst_seconds", {26'd0, seconds}, 32'd0);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_expired", {31'd0, expired}, 32'd0);
    check("rst_done_pulse", {31'd0, done_pulse}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    mon_en = 1'b1;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    do_load(8'd0, 6'd2, 8'd0, 6'd2);
    do_start();
    e0 = cyc;
    push(e0 + 4,  8'd0, 6'd1, 1'b0);
    push(e0 + 8,  8'd0, 6'd0, 1'b1);
    push(e0 + 9,  8'd0, 6'd2, 1'b0);
    push(e0 + 12, 8'd0, 6'd1, 1'b0);
    push(e0 + 16, 8'd0, 6'd0, 1'b1);
    push(e0 + 17, 8'd0, 6'd2, 1'b0);
    step(8);
    check("ar_expired_at_zero", {31'd0, expired}, 32'd0);
    check("ar_running_at_zero", {31'd0, running}, 32'd1);
    step(10);
    check("ar_expired_later", {31'd0, expired}, 32'd0);
    check("ar_running_later", {31'd0, running}, 32'd1);
    do_clear();
`else
    do_load(8'd0, 6'd3, 8'd0, 6'd3);
    check("idle_after_load", {31'd0, running}, 32'd0);
    do_start();
    e0 = cyc;
    push(e0 + 4,  8'd0, 6'd2, 1'b0);
    push(e0 + 8,  8'd0, 6'd1, 1'b0);
    push(e0 + 12, 8'd0, 6'd0, 1'b1);
    check("running_after_start", {31'd0, running}, 32'd1);
    step(12);
    check("done_pulse_high", {31'd0, done_pulse}, 32'd1);
    check("expired_in_done", {31'd0, expired}, 32'd1);
    check("running_in_done", {31'd0, running}, 32'd0);
    step(1);
    check("done_pulse_one_cycle", {31'd0, done_pulse}, 32'd0);
    do_start();
    step(3);
    check("start_at_zero_expired", {31'd0, expired}, 32'd1);
    check("start_at_zero_running", {31'd0, running}, 32'd0);
`endif

    do_load(8'd2, 6'd0, 8'd2, 6'd0);
    do_start();
    push(cyc + 4, 8'd1, 6'd59, 1'b0);
    step(4);
    do_load(8'd0, 6'd0, 8'd0, 6'd0);
    do_start();
    step(5);
    check("zero_start_running", {31'd0, running}, 32'd0);
    check("zero_start_expired", {31'd0, expired}, 32'd0);

    do_load(8'd150, 6'd63, 8'd99, 6'd59);
    check("sat_minutes", {24'd0, minutes}, 32'd99);
    check("sat_seconds", {26'd0, seconds}, 32'd59);

    do_load(8'd0, 6'd5, 8'd0, 6'd5);
    do_start();
    push(cyc + 4, 8'd0, 6'd4, 1'b0);
    step(6);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    check("paused_running", {31'd0, running}, 32'd0);
    step(20);
    do_start();
    push(cyc + 2, 8'd0, 6'd3, 1'b0);
    check("resumed_running", {31'd0, running}, 32'd1);
    step(2);
    do_clear();
    check("clear_running", {31'd0, running}, 32'd0);
    check("clear_expired", {31'd0, expired}, 32'd0);

    do_load(8'd0, 6'd2, 8'd0, 6'd2);
    do_start();
    step(3);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    step(2);
    do_start();
    push(cyc + 1, 8'd0, 6'd1, 1'b0);
    step(1);
    do_clear();

    do_load(8'd0, 6'd2, 8'd0, 6'd2);
    do_start();
    step(3);
    do_load(8'd0, 6'd8, 8'd0, 6'd8);
    step(6);
    check("tick_vs_load_running", {31'd0, running}, 32'd0);

    clear = 1'b1;
    load = 1'b1;
    load_min = 8'd5;
    load_sec = 6'd5;
    push(cyc + 1, 8'd0, 6'd0, 1'b0);
    step(1);
    clear = 1'b0;
    load = 1'b0;
    check("clear_over_load_running", {31'd0, running}, 32'd0);
    step(2);

    do_load(8'd0, 6'd9, 8'd0, 6'd9);
    do_start();
    push(cyc + 4, 8'd0, 6'd8, 1'b0);
    step(6);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_minutes", {24'd0, minutes}, 32'd0);
    check("arst_seconds", {26'd0, seconds}, 32'd0);
    check("arst_running", {31'd0, running}, 32'd0);
    check("arst_expired", {31'd0, expired}, 32'd0);
    #2 rst_n = 1'b1;
    step(2);
    mon_en = 1'b1;
    step(6);
    check("post_reset_running", {31'd0, running}, 32'd0);

    check("scoreboard_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
